ber_pair_aligner: RTL and testbench

- Upstream feeder for the audio/text bit-error counters.
- Buffers transmitted words until the matching received word comes back through the channel.
- Presents each time-aligned pair on pattern1/pattern2 with a one-cycle enable pulse, which drives the counter's enable input directly.
- Absorbs variable channel latency of up to DEPTH words and flags loss of alignment.

---
 rtl/ber_pkg.sv | 20 ++
 rtl/ber_sync_fifo.sv | 88 ++++++++
 rtl/ber_pair_aligner.sv | 182 ++++++++++++++++++
 tb/tb_ber_pair_aligner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// rtl/ber_pkg.sv - shared types and default constants for the BER pair aligner
//
// Purpose: FSM state encoding and default widths/depth for the audio and text
//          bit-error counter feeders.
// Ports:   none (package).

package ber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } ber_state_e;

  localparam int AUDIO_W   = 12;
  localparam int TEXT_W    = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/ber_sync_fifo.sv
// rtl/ber_sync_fifo.sv - WIDTH x DEPTH register FIFO with explicit occupancy
//
// Purpose: holds transmitted words in flight until their received partner
//          arrives. Occupancy is tracked separately from the pointers so full
//          and empty are unambiguous.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-low
//   flush  - synchronous empty (pointers and level to zero)
//   push   - write wdata; accepted when not full, or when full with pop
//   wdata  - word to write
//   pop    - discard the oldest word; ignored when empty
//   rdata  - oldest word (combinational view of the head)
//   level  - occupancy, 0..DEPTH
//   full   - level == DEPTH
//   empty  - level == 0

import ber_pkg::*;

module ber_sync_fifo #(
  parameter int WIDTH = AUDIO_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign w_do_push = push && (!w_full || pop);
  assign w_do_pop  = pop && !w_empty;

  // Storage carries no reset; stale entries are never visible because level
  // gates every read.
  always_ff @(posedge clock) begin
    if (w_do_push && reset && !flush) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: rtl/ber_pair_aligner.sv
// rtl/ber_pair_aligner.sv - time-aligns tx/rx words for the bit-error counters
//
// Purpose: buffers transmitted words until the matching received word returns
//          through the channel, then presents the pair on pattern1/pattern2
//          with a one-cycle enable pulse. Flags dropped tx words (overflow,
//          alignment lost -> FAULT) and rx words with no partner (underflow).
// Ports:
//   clock     - system clock, rising edge
//   reset     - synchronous, active-low; priority over clear
//   start     - level; 1 = accept traffic, 0 = idle (FIFO retained)
//   clear     - synchronous flush of FIFO, flags, counter; back to IDLE
//   tx_valid  - tx_data is a transmitted word
//   tx_data   - transmitted word
//   rx_valid  - rx_data is a received word
//   rx_data   - received word
//   pattern1  - registered tx word of the current pair
//   pattern2  - registered rx word of the current pair
//   enable    - one-cycle pulse, pattern1/pattern2 valid
//   level     - FIFO occupancy
//   pairs     - pairs emitted, saturating
//   overflow  - sticky, a tx word was dropped
//   underflow - sticky, an rx word arrived with no tx partner

module ber_pair_aligner
  import ber_pkg::*;
#(
  parameter int WIDTH = AUDIO_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     tx_valid,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     rx_valid,
  input  logic [WIDTH-1:0]         rx_data,
  output logic [WIDTH-1:0]         pattern1,
  output logic [WIDTH-1:0]         pattern2,
  output logic                     enable,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pairs,
  output logic                     overflow,
  output logic                     underflow
);

  ber_state_e r_state;
  ber_state_e w_state_nxt;

  logic [WIDTH-1:0] r_pattern1;
  logic [WIDTH-1:0] r_pattern2;
  logic             r_enable;
  logic [CNT_W-1:0] r_pairs;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;
  logic             w_pair;
  logic             w_bypass;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic [WIDTH-1:0] w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  ber_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (clear),
    .push  (w_push),
    .wdata (tx_data),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .level (level),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle datapath controls. clear overrides all traffic;
  // the edge that leaves IDLE never carries traffic.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_pair      = 1'b0;
    w_bypass    = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!start) begin
            w_state_nxt = ST_IDLE;
          end else if (tx_valid && rx_valid) begin
            w_pair = 1'b1;
            if (w_fifo_empty) begin
              // Zero channel latency: pair directly, nothing enters the FIFO.
              w_bypass = 1'b1;
            end else begin
              w_push = 1'b1;
              w_pop  = 1'b1;
            end
          end else if (tx_valid) begin
            if (w_fifo_full) begin
              w_set_ovf   = 1'b1;
              w_state_nxt = ST_FAULT;
            end else begin
              w_push = 1'b1;
            end
          end else if (rx_valid) begin
            if (w_fifo_empty) begin
              w_set_unf = 1'b1;
            end else begin
              w_pop  = 1'b1;
              w_pair = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      r_pattern1  <= '0;
      r_pattern2  <= '0;
      r_enable    <= 1'b0;
      r_pairs     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_enable <= w_pair;
      if (w_pair) begin
        r_pattern1 <= w_bypass ? tx_data : w_fifo_rdata;
        r_pattern2 <= rx_data;
        if (r_pairs != '1) begin
          r_pairs <= r_pairs + CNT_W'(1);
        end
      end
      if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_set_unf) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign pattern1  = r_pattern1;
  assign pattern2  = r_pattern2;
  assign enable    = r_enable;
  assign pairs     = r_pairs;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ber_pair_aligner.sv
// tb/tb_ber_pair_aligner.sv - scoreboard bench for ber_pair_aligner

module tb_ber_pair_aligner;

  localparam int WIDTH = 12;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             clear;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic [WIDTH-1:0] pattern1;
  logic [WIDTH-1:0] pattern2;
  logic             enable;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] pairs;
  logic             overflow;
  logic             underflow;

  ber_pair_aligner #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .pattern1  (pattern1),
    .pattern2  (pattern2),
    .enable    (enable),
    .level     (level),
    .pairs     (pairs),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: 0 idle, 1 running, 2 faulted
  int               m_mode = 0;
  logic [WIDTH-1:0] m_fifo [$];
  int               m_pairs = 0;
  bit               m_ovf = 0;
  bit               m_unf = 0;
  logic [2*WIDTH-1:0] exp_q [$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_wipe();
    m_mode = 0;
    m_fifo.delete();
    m_pairs = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_pair(input logic [WIDTH-1:0] p1, input logic [WIDTH-1:0] p2);
    exp_q.push_back({p1, p2});
    if (m_pairs < (1 << CNT_W) - 1) m_pairs++;
  endtask

  task automatic step(input bit s, input bit c, input bit r,
                      input bit tv, input logic [WIDTH-1:0] td,
                      input bit rv, input logic [WIDTH-1:0] rd);
    bit paired;
    bit wiped;
    paired = 0;
    wiped  = 0;
    start = s; clear = c; reset = r;
    tx_valid = tv; tx_data = td; rx_valid = rv; rx_data = rd;
    if (!r || c) begin
      model_wipe();
      wiped = 1;
    end else if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!s) begin
        m_mode = 0;
      end else if (tv && rv) begin
        paired = 1;
        if (m_fifo.size() == 0) begin
          model_pair(td, rd);
        end else begin
          model_pair(m_fifo.pop_front(), rd);
          m_fifo.push_back(td);
        end
      end else if (tv) begin
        if (m_fifo.size() == DEPTH) begin
          m_ovf = 1;
          m_mode = 2;
        end else begin
          m_fifo.push_back(td);
        end
      end else if (rv) begin
        if (m_fifo.size() == 0) begin
          m_unf = 1;
        end else begin
          paired = 1;
          model_pair(m_fifo.pop_front(), rd);
        end
      end
    end
    @(posedge clock);
    #1;
    chk("enable", enable, paired);
    chk("level", level, m_fifo.size());
    chk("pairs", pairs, m_pairs);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    if (wiped) begin
      chk("pattern1_zero", pattern1, 0);
      chk("pattern2_zero", pattern2, 0);
    end
  endtask

  // Monitor: every enable pulse must match the oldest outstanding pair.
  always @(negedge clock) begin
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pair_extra: got p1=0x%0h p2=0x%0h expected no pair", pattern1, pattern2);
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("pattern1", pattern1, e[2*WIDTH-1:WIDTH]);
        chk("pattern2", pattern2, e[WIDTH-1:0]);
      end
    end
  end

  initial begin
    int tx_pct;
    int rx_pct;
    start = 0; clear = 0; reset = 0;
    tx_valid = 0; tx_data = '0; rx_valid = 0; rx_data = '0;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // IDLE ignores traffic
    step(0, 0, 1, 1, 12'h111, 1, 12'h111);
    step(1, 0, 1, 1, 12'h222, 1, 12'h222);

    // latency 3 with one corrupted rx word
    step(1, 0, 1, 1, 12'hABC, 0, 0);
    step(1, 0, 1, 1, 12'h123, 0, 0);
    step(1, 0, 1, 1, 12'h5A5, 0, 0);
    step(1, 0, 1, 0, 0, 1, 12'hABC);
    step(1, 0, 1, 0, 0, 1, 12'h120);
    step(1, 0, 1, 0, 0, 1, 12'h5A5);
    step(1, 0, 1, 0, 0, 0, 0);

    // bypass at level 0
    step(1, 0, 1, 1, 12'h0FF, 1, 12'h0FE);
    step(1, 0, 1, 0, 0, 0, 0);

    // underflow, then normal alignment
    step(1, 0, 1, 0, 0, 1, 12'h777);
    step(1, 0, 1, 1, 12'h321, 0, 0);
    step(1, 0, 1, 0, 0, 1, 12'h321);

    // fill, full with simultaneous rx, overflow, fault, clear
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 1, WIDTH'(12'h800 + i), 0, 0);
    step(1, 0, 1, 1, 12'h9AA, 1, 12'h800);
    step(1, 0, 1, 1, 12'h9BB, 0, 0);
    step(1, 0, 1, 0, 0, 1, 12'h801);
    step(1, 0, 1, 1, 12'h9CC, 1, 12'h802);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // start deasserted retains FIFO contents
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 12'h4A1, 0, 0);
    step(1, 0, 1, 1, 12'h4A2, 0, 0);
    step(0, 0, 1, 0, 0, 1, 12'h4A1);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 12'h4A1);
    step(1, 0, 1, 0, 0, 1, 12'h4A2);

    // reset mid-operation with rx_valid
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, WIDTH'(12'h300 + i), 0, 0);
    step(1, 0, 0, 0, 0, 1, 12'h300);
    step(1, 0, 1, 1, 12'h310, 1, 12'h310);
    step(1, 0, 1, 1, 12'h311, 1, 12'h311);

    // randomized traffic with varying channel pressure
    for (int blk = 0; blk < 20; blk++) begin
      tx_pct = $urandom_range(20, 90);
      rx_pct = $urandom_range(20, 90);
      for (int i = 0; i < 150; i++) begin
        step(($urandom % 25) != 0,
             ($urandom % 120) == 0,
             ($urandom % 500) != 0,
             $urandom_range(0, 99) < tx_pct, WIDTH'($urandom),
             $urandom_range(0, 99) < rx_pct, WIDTH'($urandom));
      end
    end

    step(1, 0, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("pairs_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
